// File: rtl/conv2d_stream3x3.sv
// conv2d_stream3x3: streaming 3x3 valid-mode 2-D convolution with saturation and valid/ready handshakes
// Ports: clk, rst (sync, active-high); start latches kernel and begins a frame;
// in_valid/in_data/in_ready is the raster pixel stream; out_valid/out_data/out_last/out_ready
// is the result stream; busy is high during a frame; done pulses after the last result is taken.
module conv2d_stream3x3 #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9*COEF_W-1:0]   kernel,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int ACC_W = DATA_W + COEF_W + 5;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(IMG_W * IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [PW-1:0] PIX_N = PW'(IMG_W * IMG_H);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [9*COEF_W-1:0] coef;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win [3][3];
  logic [DATA_W-1:0] col_in [3];
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] pix_cnt;
  logic signed [ACC_W-1:0] acc, y;
  logic [OUT_W-1:0] sat;
  logic take, emit;
  assign in_ready = state == RUN && pix_cnt < PIX_N && (!out_valid || out_ready);
  assign take = in_valid && in_ready;
  // only windows fully inside the frame (no wrap across rows) produce results
  assign emit = take && row >= RW'(2) && col >= CW'(2);
  // the result is computed from the window as it will look after this pixel shifts in
  always_comb begin
    col_in[0] = lb0[col];
    col_in[1] = lb1[col];
    col_in[2] = in_data;
    acc = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc = acc + ACC_W'(c == 2 ? col_in[r] : win[r][(c + 1) % 3]) *
                    ACC_W'($signed(coef[(3 * r + c) * COEF_W +: COEF_W]));
    y = acc >>> SHIFT;
    sat = y > SAT_MAX ? SAT_MAX[OUT_W-1:0] : y < SAT_MIN ? SAT_MIN[OUT_W-1:0] : y[OUT_W-1:0];
  end
  always_ff @(posedge clk)
    if (take) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_data;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      col <= '0;
      row <= '0;
      pix_cnt <= '0;
      coef <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      done <= state == RUN && out_valid && out_ready && out_last;
      if (state == IDLE && start) begin
        state <= RUN;
        busy <= 1'b1;
        coef <= kernel;
        col <= '0;
        row <= '0;
        pix_cnt <= '0;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state == RUN && out_valid && out_ready && out_last) begin
        state <= DONE;
        busy <= 1'b0;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (take) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
          win[r][2] <= col_in[r];
        end
        pix_cnt <= pix_cnt + 1'b1;
        col <= col == COL_MAX ? '0 : col + 1'b1;
        row <= col == COL_MAX ? row + 1'b1 : row;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data <= sat;
        out_last <= row == ROW_MAX && col == COL_MAX;
      end
    end
  end
endmodule

// File: tb/tb_conv2d_stream3x3.sv
// tb_conv2d_stream3x3: directed self-checking bench for conv2d_stream3x3 against a direct-convolution model
module tb_conv2d_stream3x3;
  typedef struct {int v; int l;} exp_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
  bit sel = 0, rand_ready = 0;
  logic [71:0] kernel = '0;
  logic [7:0] in_data = '0;
  logic a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic signed [15:0] a_out_data, b_out_data;
  int n_chk = 0, n_fail = 0;
  int pix[$];
  int kk[9];
  exp_t eq[$];
  int held_v[2], held_d[2], held_l[2], exp_done[2];

  always #5 clk = ~clk;

  conv2d_stream3x3 #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .kernel(kernel),
    .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(out_ready), .busy(a_busy), .done(a_done));

  conv2d_stream3x3 #(.IMG_W(8), .IMG_H(4), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .kernel(kernel),
    .in_valid(in_valid && sel), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(out_ready), .busy(b_busy), .done(b_done));

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // direct valid-mode convolution over the whole frame held in pix
  task automatic fill_expected(input int w, input int h, input int sh);
    eq.delete();
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        int s = 0;
        exp_t e;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += pix[(r - 2 + i) * w + c - 2 + j] * kk[3 * i + j];
        s = s >>> sh;
        s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
        e.v = s;
        e.l = (r == h - 1 && c == w - 1) ? 1 : 0;
        eq.push_back(e);
      end
  endtask

  task automatic set_kernel();
    for (int i = 0; i < 9; i++) kernel[i*8 +: 8] = 8'(kk[i]);
  endtask

  task automatic check_dut(input int s, input logic v, input logic signed [15:0] d, input logic l, input logic dn);
    exp_t e;
    chk($sformatf("done_dut%0d", s), int'(dn), exp_done[s]);
    if (held_v[s] != 0) begin
      chk($sformatf("hold_valid_dut%0d", s), int'(v), 1);
      chk($sformatf("hold_data_dut%0d", s), int'(d), held_d[s]);
      chk($sformatf("hold_last_dut%0d", s), int'(l), held_l[s]);
    end
    if (v && out_ready) begin
      if (eq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output_dut%0d: got %0d, expected no output", s, d);
      end else begin
        e = eq.pop_front();
        chk($sformatf("out_data_dut%0d", s), int'(d), e.v);
        chk($sformatf("out_last_dut%0d", s), int'(l), e.l);
      end
    end
    exp_done[s] = (v && out_ready && l) ? 1 : 0;
    held_v[s] = (v && !out_ready) ? 1 : 0;
    held_d[s] = int'(d);
    held_l[s] = int'(l);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      held_v = '{0, 0};
      exp_done = '{0, 0};
    end else begin
      check_dut(0, a_out_valid, a_out_data, a_out_last, a_done);
      check_dut(1, b_out_valid, b_out_data, b_out_last, b_done);
    end
  end

  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_ready ? ($urandom_range(99) < 60) : 1'b1;
  end

  task automatic run_frame(input bit s, input int gap, input int npix, input bit mid);
    int i = 0, cyc = 0, got = 0;
    bit took, smid = 0;
    sel = s;
    set_kernel();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("busy_running", int'(s ? b_busy : a_busy), 1);
    @(posedge clk);
    #1;
    while (i < npix && cyc < 3000) begin
      in_valid = $urandom_range(99) >= gap;
      in_data = 8'(pix[i]);
      if (mid && i == 10 && !smid) begin
        start = 1;
        smid = 1;
        for (int k = 0; k < 9; k++) kernel[k*8 +: 8] = 8'd2;
      end else start = 0;
      @(negedge clk);
      took = in_valid && (s ? b_in_ready : a_in_ready);
      @(posedge clk);
      #1;
      if (took) i++;
      cyc++;
    end
    in_valid = 0;
    start = 0;
    chk("pixels_accepted", i, npix);
    if (npix == pix.size()) begin
      in_valid = 1;
      @(negedge clk);
      chk("in_ready_frame_full", int'(s ? b_in_ready : a_in_ready), 0);
      @(posedge clk);
      #1 in_valid = 0;
      for (int t = 0; t < 500; t++) begin
        @(negedge clk);
        if (s ? b_done : a_done) begin
          got = 1;
          break;
        end
      end
      chk("done_seen", got, 1);
      chk("outputs_remaining", eq.size(), 0);
      chk("busy_after_frame", int'(s ? b_busy : a_busy), 0);
    end
  endtask

  task automatic load_ramp(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(i + 1);
  endtask

  initial begin
    int lit1[9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    int lit4[12] = '{9, 10, 11, 12, 13, 14, 17, 18, 19, 20, 21, 22};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_data", int'(a_out_data), 0);
    chk("rst_out_last", int'(a_out_last), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_b_out_valid", int'(b_out_valid), 0);
    // ramp frame, unit kernel
    load_ramp(25);
    for (int i = 0; i < 9; i++) kk[i] = 1;
    fill_expected(5, 5, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("model_ramp_%0d", i), eq[i].v, lit1[i]);
    chk("model_ramp_last", eq[8].l, 1);
    run_frame(0, 0, 25, 0);
    // same frame with input gaps and output backpressure
    rand_ready = 1;
    fill_expected(5, 5, 0);
    run_frame(0, 30, 25, 0);
    rand_ready = 0;
    // positive and negative saturation
    pix.delete();
    for (int i = 0; i < 25; i++) pix.push_back(255);
    for (int i = 0; i < 9; i++) kk[i] = 127;
    fill_expected(5, 5, 0);
    chk("model_sat_pos", eq[4].v, 32767);
    run_frame(0, 0, 25, 0);
    for (int i = 0; i < 9; i++) kk[i] = -128;
    fill_expected(5, 5, 0);
    chk("model_sat_neg", eq[4].v, -32768);
    run_frame(0, 0, 25, 0);
    // 8x4 frame, shift 2, centre-only kernel
    pix.delete();
    for (int i = 0; i < 32; i++) pix.push_back(i);
    for (int i = 0; i < 9; i++) kk[i] = (i == 4) ? 4 : 0;
    fill_expected(8, 4, 2);
    for (int i = 0; i < 12; i++) chk($sformatf("model_shift_%0d", i), eq[i].v, lit4[i]);
    run_frame(1, 20, 32, 0);
    // reset part-way through a frame, then a clean rerun
    load_ramp(25);
    for (int i = 0; i < 9; i++) kk[i] = 1;
    fill_expected(5, 5, 0);
    run_frame(0, 0, 13, 0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", int'(a_out_valid), 0);
    chk("midrst_out_data", int'(a_out_data), 0);
    chk("midrst_out_last", int'(a_out_last), 0);
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_in_ready", int'(a_in_ready), 0);
    @(posedge clk);
    #1 rst = 0;
    fill_expected(5, 5, 0);
    run_frame(0, 0, 25, 0);
    // start pulse with a new kernel during a frame is ignored
    rand_ready = 1;
    fill_expected(5, 5, 0);
    run_frame(0, 10, 25, 1);
    rand_ready = 0;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
